// File: rtl/btb_ctrl.sv
// Direct-mapped branch target buffer controller: arbitrates lookups/updates and sweeps valid bits.
// Optional hit/miss statistics counters are enabled by defining BTB_STATS_EN.
module btb_ctrl #(
  parameter int IDX_W = 6,
  parameter int TGT_W = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lu_req,
  input  logic [31:0] lu_pc,
  input  logic        lu_kill,
  output logic        lu_ack,
  output logic        lu_hit,
  output logic        lu_taken,
  output logic [31:0] lu_target,
  input  logic        up_req,
  input  logic [31:0] up_pc,
  input  logic [31:0] up_target,
  input  logic        up_taken,
  output logic        up_ack,
  input  logic        inv_all,
`ifdef BTB_STATS_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  output logic        busy
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  typedef enum logic [1:0] {SWEEP, IDLE, LOOKUP, UPDATE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   sweep_idx;
  logic               valid_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [TGT_W-1:0]   tgt_q   [ENTRIES];
  logic [1:0]         ctr_q   [ENTRIES];

  logic [IDX_W-1:0]   lu_idx, up_idx;
  logic [TAG_W-1:0]   lu_tag, up_tag;
  logic               lu_raw_hit, up_match, lu_fire, up_fire;
  logic               unused_bits;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    else       return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lu_idx      = lu_pc[IDX_W+1:2];
  assign lu_tag      = lu_pc[31:IDX_W+2];
  assign up_idx      = up_pc[IDX_W+1:2];
  assign up_tag      = up_pc[31:IDX_W+2];
  assign lu_raw_hit  = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign up_match    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign unused_bits = ^{lu_pc[1:0], up_pc[1:0], up_target[1:0]};

  // A reset arriving during LOOKUP/UPDATE suppresses that cycle's ack and write
  assign lu_fire = (state == LOOKUP) && !rst;
  assign up_fire = (state == UPDATE) && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      SWEEP:  if (!inv_all && (&sweep_idx)) state_nxt = IDLE;
      IDLE: begin
        if (inv_all)     state_nxt = SWEEP;
        else if (up_req) state_nxt = UPDATE;
        else if (lu_req) state_nxt = LOOKUP;
      end
      default: state_nxt = inv_all ? SWEEP : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP && !inv_all) sweep_idx <= sweep_idx + 1'b1;
      else                            sweep_idx <= '0;
    end
  end

  // Single write port: sweep clears a valid bit, update allocates or trains an entry
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      valid_q[sweep_idx] <= 1'b0;
    end else if (up_fire) begin
      tgt_q[up_idx] <= up_target[TGT_W+1:2];
      if (up_match) begin
        ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], up_taken);
      end else begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        ctr_q[up_idx]   <= up_taken ? 2'd2 : 2'd1;
      end
    end
  end

  always_comb begin
    lu_ack    = lu_fire;
    lu_hit    = lu_fire && lu_raw_hit && !lu_kill;
    lu_taken  = lu_hit && ctr_q[lu_idx][1];
    lu_target = lu_hit ? 32'({tgt_q[lu_idx], 2'b00}) : 32'd0;
    up_ack    = up_fire;
    busy      = rst || (state == SWEEP);
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lu_fire) begin
      if (lu_hit) hit_cnt  <= sat_inc16(hit_cnt);
      else        miss_cnt <= sat_inc16(miss_cnt);
    end
  end
`endif

endmodule
